psum_collector: RTL and testbench
=================================

Name: psum_collector

Overview:
- Sits at the bottom edge of the systolic PE array and collects the 20-bit partial sums that leave each PE column.
- The array emits a result row skewed in time: column c produces its value c cycles after column 0. This block de-skews the COLS column streams into one aligned row and buffers rows in a small FIFO.
- It delivers rows downstream over a valid/ready handshake and flags skew errors and overflow.

Parameters:
- COLS, 4, number of PE columns (2..16).
- PSUM_W, 20, partial-sum width per column; two's complement.
- DEPTH, 4, FIFO depth in rows; power of two, 2..16.
- CNT_W, 16, width of the accepted-row counter.

Ports:
- clk  input  1  single clock; all logic updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- col_valid  input  COLS  bit c = column c psum valid this cycle.
- col_psum  input  COLS*PSUM_W  column c occupies bits [c*PSUM_W +: PSUM_W].
- row_valid  output  1  FIFO head row available.
- row_ready  input  1  downstream accepts the head row.
- row_data  output  COLS*PSUM_W  aligned row, same packing as col_psum.
- fifo_full  output  1  FIFO holds DEPTH rows.
- overflow  output  1  sticky; an aligned row was dropped because the FIFO was full.
- skew_err  output  1  sticky; a partial aligned row was seen.
- rows_done  output  CNT_W  count of rows written into the FIFO.

Behaviour:
- Reset, synchronous, active-high. When reset is high at an edge:
  - all delay lines are cleared (valid and data to 0);
  - FIFO is emptied;
  - row_valid=0, row_data=0, fifo_full=0, overflow=0, skew_err=0, rows_done=0.
  - Reset mid-operation discards all in-flight and buffered rows. No output is produced from them.
- De-skew:
  - Column c passes through D(c) = COLS-1-c register stages, carrying valid and data together.
  - Column COLS-1 has zero delay.
  - Aligned view: valid vector av[c] and data ad[c] at the end of each column's delay line.
- Row accept:
  - When all bits of av are 1, the aligned row is a candidate for writing.
  - If a column-0 value is sampled at edge T, the row is written at edge T+COLS-1.
  - row_valid rises in the following cycle if the FIFO was empty (first-word fall-through, registered head).
- Skew error: if av is neither all-0 nor all-1, skew_err is set and that row is discarded. Nothing is written and rows_done is unchanged.
- FIFO write:
  - A candidate row is written if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
  - Otherwise the row is dropped and overflow is set (sticky until reset).
- FIFO read: a pop occurs when row_valid && row_ready. The head advances at that edge.
  - row_data is held stable while row_valid=1 and row_ready=0.
  - With row_valid=0, row_ready is ignored and row_data holds its last value.
- Simultaneous push and pop:
  - Occupancy is unchanged.
  - When empty, push and pop cannot coincide, because row_valid=0.
- fifo_full equals (occupancy == DEPTH) and is registered alongside the pointers.
- Pointers: log2(DEPTH)+1 bits each; wrap modulo 2*DEPTH; full/empty are derived from MSB comparison.
- rows_done increments by 1 on each successful FIFO write and wraps from 2^CNT_W-1 to 0.
- Data is passed bit-exact, with no arithmetic applied (except the optional feature below).
- col_psum lanes whose col_valid bit is 0 are don't-care.

Optional Feature:
- Macro: PSUM_RELU_EN.
- Defined: each PSUM_W lane of row_data is forced to 0 when its MSB is 1, i.e. ReLU on negative psums. The clamp is applied at FIFO write time, so it adds no latency, and FIFO contents are already clamped.
- Not defined: row_data is the raw two's-complement psum.
- All other behaviour, including the counters and flags, is identical in both builds.

Test Plan:
- Single row, COLS=4, row_ready=1: col0=0x00010 at edge 0, col1=0x00020 at edge 1, col2=0x00030 at edge 2, col3=0x00040 at edge 3 -> row_valid rises after edge 3; row_data = {0x00040,0x00030,0x00020,0x00010}; rows_done=1; skew_err=0.
- Back-to-back streaming: 8 skewed rows, one per cycle, with values row r lane c = r*16+c and row_ready=1 -> 8 consecutive row_valid cycles, rows in order, rows_done=8, overflow=0.
- Backpressure and overflow with DEPTH=4: row_ready=0, 5 rows pushed -> fifo_full=1 after the 4th row, the 5th row is dropped, overflow=1, rows_done=4. Then raise row_ready -> exactly 4 rows are drained, in order 0..3.
- Full with simultaneous pop: fill to 4 rows, then push the 5th row in the same cycle as a pop -> no overflow, occupancy stays 4, rows_done=5.
- Skew error: assert col_valid[2] one cycle late for one row -> skew_err=1, no row written, rows_done unchanged. A following correct row is still accepted.
- Reset mid-operation: 2 rows buffered plus 1 row in flight, then reset asserted for 1 cycle -> row_valid=0, all flags and rows_done=0, and no row emerges afterwards. With PSUM_RELU_EN defined, lane value 0xFFFF0 is output as 0x00000.

Source files
------------

// File: rtl/psum_collector.sv
// Partial-sum collector: de-skews the per-column psum streams of the PE array into aligned rows and buffers them in a FIFO.
// Optional build macro PSUM_RELU_EN clamps negative lanes to zero at FIFO write time.
module psum_collector #(
  parameter int COLS   = 4,
  parameter int PSUM_W = 20,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [COLS-1:0]        col_valid,
  input  logic [COLS*PSUM_W-1:0] col_psum,
  output logic                   row_valid,
  input  logic                   row_ready,
  output logic [COLS*PSUM_W-1:0] row_data,
  output logic                   fifo_full,
  output logic                   overflow,
  output logic                   skew_err,
  output logic [CNT_W-1:0]       rows_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = COLS * PSUM_W;

  logic [COLS-1:0] av;
  logic [RW-1:0]   aligned_row;

  // Column c is delayed COLS-1-c cycles so that all lanes of one row line up.
  for (genvar c = 0; c < COLS; c++) begin : g_col
    if (c == COLS - 1) begin : g_direct
      assign av[c]                             = col_valid[c];
      assign aligned_row[c*PSUM_W +: PSUM_W]   = col_psum[c*PSUM_W +: PSUM_W];
    end else begin : g_delay
      localparam int D = COLS - 1 - c;
      logic [D-1:0]      v_q;
      logic [PSUM_W-1:0] d_q [D];

      // NOTE: sequential state uses non-blocking assignments so every stage samples the pre-edge value of its neighbour.
      always_ff @(posedge clk) begin
        if (reset) begin
          v_q <= '0;
          for (int k = 0; k < D; k++) d_q[k] <= '0;
        end else begin
          v_q[0] <= col_valid[c];
          d_q[0] <= col_psum[c*PSUM_W +: PSUM_W];
          for (int k = 1; k < D; k++) begin
            v_q[k] <= v_q[k-1];
            d_q[k] <= d_q[k-1];
          end
        end
      end

      assign av[c]                           = v_q[D-1];
      assign aligned_row[c*PSUM_W +: PSUM_W] = d_q[D-1];
    end
  end

  logic          all_valid;
  logic          part_valid;
  logic          pop;
  logic          push;
  logic          empty;
  logic [RW-1:0] wdata;
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [AW:0]   wr_nxt, rd_nxt;
  logic          full_nxt;
  logic [RW-1:0] mem [DEPTH];
  logic [RW-1:0] head_q;
  logic          full_q;
  logic          overflow_q;
  logic          skew_q;
  logic [CNT_W-1:0] rows_q;

  assign all_valid  = &av;
  assign part_valid = (|av) & ~all_valid;
  assign empty      = (wr_ptr == rd_ptr);
  assign pop        = ~empty & row_ready;
  assign push       = all_valid & (~full_q | pop);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    wdata = aligned_row;
`ifdef PSUM_RELU_EN
    for (int c = 0; c < COLS; c++) begin
      if (wdata[c*PSUM_W + PSUM_W - 1]) wdata[c*PSUM_W +: PSUM_W] = '0;
    end
`endif
  end

  always_comb begin
    wr_nxt   = wr_ptr + (AW+1)'(push);
    rd_nxt   = rd_ptr + (AW+1)'(pop);
    full_nxt = (wr_nxt[AW] != rd_nxt[AW]) && (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);
  end

  // NOTE: the row storage is not reset; the head register and pointers alone define what is visible.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      full_q     <= 1'b0;
      head_q     <= '0;
      overflow_q <= 1'b0;
      skew_q     <= 1'b0;
      rows_q     <= '0;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      full_q <= full_nxt;
      // The head slot may be the one being written this very edge; bypass it then.
      if (wr_nxt != rd_nxt) begin
        if (push && (rd_nxt[AW-1:0] == wr_ptr[AW-1:0])) head_q <= wdata;
        else                                            head_q <= mem[rd_nxt[AW-1:0]];
      end
      if (all_valid && !push) overflow_q <= 1'b1;
      if (part_valid)         skew_q     <= 1'b1;
      if (push)               rows_q     <= rows_q + 1'b1;
    end
  end

  assign row_valid = ~empty;
  assign row_data  = head_q;
  assign fifo_full = full_q;
  assign overflow  = overflow_q;
  assign skew_err  = skew_q;
  assign rows_done = rows_q;

endmodule

// File: tb/tb_psum_collector.sv
// Directed self-checking bench for psum_collector (COLS=4, PSUM_W=20, DEPTH=4).
// Stimulus schedules skewed rows; popped rows are captured and compared with hand-built expectations.
module tb_psum_collector;

  localparam int COLS   = 4;
  localparam int PSUM_W = 20;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 16;
  localparam int RW     = COLS * PSUM_W;

  logic                clk = 1'b0;
  logic                reset;
  logic [COLS-1:0]     col_valid;
  logic [RW-1:0]       col_psum;
  logic                row_valid;
  logic                row_ready;
  logic [RW-1:0]       row_data;
  logic                fifo_full;
  logic                overflow;
  logic                skew_err;
  logic [CNT_W-1:0]    rows_done;

  psum_collector #(.COLS(COLS), .PSUM_W(PSUM_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .col_valid (col_valid),
    .col_psum  (col_psum),
    .row_valid (row_valid),
    .row_ready (row_ready),
    .row_data  (row_data),
    .fifo_full (fifo_full),
    .overflow  (overflow),
    .skew_err  (skew_err),
    .rows_done (rows_done)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          q_start[$];
  logic [RW-1:0] q_val[$];
  int          q_skew[$];
  logic [RW-1:0] got[$];
  int          run      = 0;
  int          max_run  = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RW-1:0] mkrow(input int r);
    logic [RW-1:0] v;
    for (int c = 0; c < COLS; c++) v[c*PSUM_W +: PSUM_W] = PSUM_W'(r*16 + c);
    return v;
  endfunction

  function automatic logic [RW-1:0] exp_row(input logic [RW-1:0] v);
    logic [RW-1:0] e;
    e = v;
`ifdef PSUM_RELU_EN
    for (int c = 0; c < COLS; c++)
      if (e[c*PSUM_W + PSUM_W - 1]) e[c*PSUM_W +: PSUM_W] = '0;
`endif
    return e;
  endfunction

  // Column 0 of a scheduled row is sampled at the next edge; column c follows c edges later.
  task automatic sched(input logic [RW-1:0] v, input int skew_lane = -1);
    q_start.push_back(cyc);
    q_val.push_back(v);
    q_skew.push_back(skew_lane);
  endtask

  task automatic tick();
    col_valid = '0;
    col_psum  = '0;
    for (int i = 0; i < q_start.size(); i++) begin
      for (int c = 0; c < COLS; c++) begin
        if (q_start[i] + c + ((c == q_skew[i]) ? 1 : 0) == cyc) begin
          col_valid[c]                  = 1'b1;
          col_psum[c*PSUM_W +: PSUM_W]  = q_val[i][c*PSUM_W +: PSUM_W];
        end
      end
    end
    if (row_valid && row_ready) got.push_back(row_data);
    if (row_valid) run++;
    else           run = 0;
    if (run > max_run) max_run = run;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    q_start.delete();
    q_val.delete();
    q_skew.delete();
    for (int i = 0; i < n; i++) tick();
    reset = 1'b0;
    got.delete();
    run     = 0;
    max_run = 0;
  endtask

  logic [RW-1:0] v1;
  logic [RW-1:0] vr;

  initial begin
    reset     = 1'b1;
    row_ready = 1'b0;
    col_valid = '0;
    col_psum  = '0;

    // Reset state
    do_reset(2);
    check("rst_row_valid", row_valid, 0);
    check("rst_row_data",  row_data,  0);
    check("rst_fifo_full", fifo_full, 0);
    check("rst_overflow",  overflow,  0);
    check("rst_skew_err",  skew_err,  0);
    check("rst_rows_done", rows_done, 0);

    // Single row: written at edge 3, visible right after it
    row_ready = 1'b1;
    v1 = {20'h00040, 20'h00030, 20'h00020, 20'h00010};
    sched(v1);
    repeat (3) tick();
    check("t1_not_yet_valid", row_valid, 0);
    tick();
    check("t1_row_valid", row_valid, 1);
    check("t1_row_data",  row_data,  exp_row(v1));
    check("t1_rows_done", rows_done, 1);
    check("t1_skew_err",  skew_err,  0);
    tick();
    check("t1_valid_drops", row_valid, 0);
    check("t1_data_holds",  row_data,  exp_row(v1));
    check("t1_popped",      got.size(), 1);

    // Back-to-back streaming of 8 rows
    do_reset(1);
    row_ready = 1'b1;
    for (int r = 0; r < 8; r++) begin
      sched(mkrow(r));
      tick();
    end
    repeat (6) tick();
    check("t2_count", got.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < got.size()) check($sformatf("t2_row%0d", i), got[i], exp_row(mkrow(i)));
    check("t2_run",       max_run,   8);
    check("t2_rows_done", rows_done, 8);
    check("t2_overflow",  overflow,  0);

    // Backpressure and overflow
    do_reset(1);
    row_ready = 1'b0;
    for (int r = 0; r < 5; r++) begin
      sched(mkrow(r));
      tick();
    end
    tick();
    check("t3_full_at_3",  fifo_full, 0);
    tick();
    check("t3_full_at_4",  fifo_full, 1);
    check("t3_no_ovf_yet", overflow,  0);
    check("t3_rows_4a",    rows_done, 4);
    tick();
    check("t3_overflow",   overflow,  1);
    check("t3_rows_4b",    rows_done, 4);
    check("t3_still_full", fifo_full, 1);
    row_ready = 1'b1;
    repeat (6) tick();
    check("t3_drained", got.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < got.size()) check($sformatf("t3_row%0d", i), got[i], exp_row(mkrow(i)));
    check("t3_empty", row_valid, 0);
    check("t3_not_full", fifo_full, 0);

    // Full FIFO with push and pop on the same edge
    do_reset(1);
    row_ready = 1'b0;
    for (int r = 0; r < 5; r++) begin
      sched(mkrow(r));
      tick();
    end
    repeat (2) tick();
    check("t4_full", fifo_full, 1);
    row_ready = 1'b1;
    tick();
    row_ready = 1'b0;
    check("t4_overflow",  overflow,  0);
    check("t4_full_kept", fifo_full, 1);
    check("t4_rows_done", rows_done, 5);
    check("t4_pop_count", got.size(), 1);
    if (got.size() > 0) check("t4_pop_row0", got[0], exp_row(mkrow(0)));
    row_ready = 1'b1;
    repeat (6) tick();
    check("t4_drain_count", got.size(), 5);
    if (got.size() == 5) check("t4_last_row", got[4], exp_row(mkrow(4)));

    // Skew error, then a correct row
    do_reset(1);
    row_ready = 1'b1;
    sched(mkrow(9), 2);
    repeat (6) tick();
    check("t5_skew_err",   skew_err,   1);
    check("t5_rows_done",  rows_done,  0);
    check("t5_no_row",     got.size(), 0);
    sched(mkrow(10));
    repeat (6) tick();
    check("t5_rows_after", rows_done,  1);
    check("t5_got_after",  got.size(), 1);
    if (got.size() > 0) check("t5_row_after", got[0], exp_row(mkrow(10)));
    check("t5_skew_sticky", skew_err, 1);

    // Reset mid-operation: 2 rows buffered, 1 row in flight
    do_reset(1);
    row_ready = 1'b0;
    for (int r = 0; r < 3; r++) begin
      sched(mkrow(r + 20));
      tick();
    end
    repeat (2) tick();
    check("t6_pre_rows", rows_done, 2);
    check("t6_pre_valid", row_valid, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    q_start.delete();
    q_val.delete();
    q_skew.delete();
    got.delete();
    check("t6_row_valid", row_valid, 0);
    check("t6_row_data",  row_data,  0);
    check("t6_full",      fifo_full, 0);
    check("t6_overflow",  overflow,  0);
    check("t6_skew",      skew_err,  0);
    check("t6_rows_done", rows_done, 0);
    row_ready = 1'b1;
    repeat (8) tick();
    check("t6_nothing_out", got.size(), 0);
    check("t6_rows_still0", rows_done,  0);

    // Negative lanes (clamped only in the ReLU build)
    do_reset(1);
    row_ready = 1'b1;
    vr = {20'h7FFFF, 20'h80000, 20'hFFFF0, 20'h00005};
    sched(vr);
    repeat (4) tick();
    check("t7_valid", row_valid, 1);
`ifdef PSUM_RELU_EN
    check("t7_row_data", row_data, {20'h7FFFF, 20'h00000, 20'h00000, 20'h00005});
`else
    check("t7_row_data", row_data, {20'h7FFFF, 20'h80000, 20'hFFFF0, 20'h00005});
`endif
    check("t7_rows_done", rows_done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
